// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron scheduler and its update datapath.
package lif_pkg;

  localparam int LIF_WIDTH           = 6;
  localparam int LIF_LEAK_SHIFT      = 1;
  localparam int LIF_RESET_THRESHOLD = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } lif_state_e;

  // True when an unsigned sum no longer fits in 'width' bits and must saturate.
  function automatic logic sat_overflow(input logic [31:0] value, input int unsigned width);
    sat_overflow = ((value >> width) != 32'd0);
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational LIF update for one neuron: leak, integrate, saturate, fire.
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int WIDTH      = LIF_WIDTH,
  parameter int LEAK_SHIFT = LIF_LEAK_SHIFT
) (
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] thr,
  input  logic             spk_prev,
  output logic [WIDTH-1:0] new_state,
  output logic             new_spk
);

  logic [WIDTH-1:0] leak_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] sat_s;

  // A neuron that just fired restarts from its input alone; thr of zero disables it.
  always_comb begin
    leak_s    = state >> LEAK_SHIFT;
    sum_s     = {(WIDTH+1){1'b0}};
    sat_s     = {WIDTH{1'b0}};
    new_state = {WIDTH{1'b0}};
    new_spk   = 1'b0;
    if (spk_prev) begin
      leak_s = {WIDTH{1'b0}};
    end else begin
      leak_s = state >> LEAK_SHIFT;
    end
    sum_s = {1'b0, in} + {1'b0, leak_s};
    if (sat_overflow(32'(sum_s), WIDTH)) begin
      sat_s = {WIDTH{1'b1}};
    end else begin
      sat_s = sum_s[WIDTH-1:0];
    end
    if (thr == {WIDTH{1'b0}}) begin
      new_state = {WIDTH{1'b0}};
      new_spk   = 1'b0;
    end else begin
      new_state = sat_s;
      new_spk   = (sat_s >= thr);
    end
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Sweeps N_NEURONS LIF neurons through one shared update unit on every tick.
module lif_neuron_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS       = 4,
  parameter int WIDTH           = LIF_WIDTH,
  parameter int LEAK_SHIFT      = LIF_LEAK_SHIFT,
  parameter int RESET_THRESHOLD = LIF_RESET_THRESHOLD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [N_NEURONS*WIDTH-1:0]   in_current,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [WIDTH-1:0]             cfg_thr,
  output logic                         busy,
  output logic                         spike_valid,
  output logic [N_NEURONS-1:0]         spike_vec,
  output logic [N_NEURONS*WIDTH-1:0]   state_out,
  output logic                         overrun
);

  localparam int                IDX_W    = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [WIDTH-1:0]  THR_INIT = WIDTH'(RESET_THRESHOLD);

  lif_state_e                 fsm_r;
  lif_state_e                 fsm_next_s;
  logic [IDX_W-1:0]           idx_r;
  logic [N_NEURONS*WIDTH-1:0] state_rf_r;
  logic [N_NEURONS*WIDTH-1:0] thr_rf_r;
  logic [N_NEURONS*WIDTH-1:0] snap_r;
  logic [N_NEURONS-1:0]       spk_rf_r;
  logic [WIDTH-1:0]           op_in_r;
  logic [WIDTH-1:0]           op_state_r;
  logic [WIDTH-1:0]           op_thr_r;
  logic                       op_spk_r;
  logic [WIDTH-1:0]           new_state_s;
  logic                       new_spk_s;
  logic [N_NEURONS*WIDTH-1:0] state_wb_s;
  logic [N_NEURONS-1:0]       spk_wb_s;
  logic                       last_s;
  logic                       cfg_hit_s;
  logic                       finish_s;

  assign last_s    = (idx_r == LAST_IDX);
  assign cfg_hit_s = cfg_we && (32'(cfg_addr) < 32'(N_NEURONS));
  // Last write-back of the sweep: outputs are loaded so they are visible in DONE.
  assign finish_s  = (fsm_r == UPDATE) && last_s;

  lif_update_unit #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT)
  ) u_update (
    .in        (op_in_r),
    .state     (op_state_r),
    .thr       (op_thr_r),
    .spk_prev  (op_spk_r),
    .new_state (new_state_s),
    .new_spk   (new_spk_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r <= IDLE;
    end else begin
      fsm_r <= fsm_next_s;
    end
  end

  // FSM next-state logic: READ/UPDATE pair per neuron, then a single DONE cycle.
  always_comb begin
    fsm_next_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (tick) begin
          fsm_next_s = READ;
        end else begin
          fsm_next_s = IDLE;
        end
      end
      READ: fsm_next_s = UPDATE;
      UPDATE: begin
        if (last_s) begin
          fsm_next_s = DONE;
        end else begin
          fsm_next_s = READ;
        end
      end
      DONE:    fsm_next_s = IDLE;
      default: fsm_next_s = IDLE;
    endcase
  end

  // Register-file images with the current neuron's result merged in during UPDATE.
  always_comb begin
    state_wb_s = state_rf_r;
    spk_wb_s   = spk_rf_r;
    if (fsm_r == UPDATE) begin
      state_wb_s[idx_r*WIDTH +: WIDTH] = new_state_s;
      spk_wb_s[idx_r]                  = new_spk_s;
    end else begin
      state_wb_s = state_rf_r;
      spk_wb_s   = spk_rf_r;
    end
  end

  // Sweep index, input snapshot and datapath operand latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r      <= {IDX_W{1'b0}};
      snap_r     <= {(N_NEURONS*WIDTH){1'b0}};
      op_in_r    <= {WIDTH{1'b0}};
      op_state_r <= {WIDTH{1'b0}};
      op_thr_r   <= {WIDTH{1'b0}};
      op_spk_r   <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (tick) begin
            idx_r  <= {IDX_W{1'b0}};
            snap_r <= in_current;
          end else begin
            snap_r <= snap_r;
          end
        end
        READ: begin
          op_in_r    <= snap_r[idx_r*WIDTH +: WIDTH];
          op_state_r <= state_rf_r[idx_r*WIDTH +: WIDTH];
          op_thr_r   <= thr_rf_r[idx_r*WIDTH +: WIDTH];
          op_spk_r   <= spk_rf_r[idx_r];
        end
        UPDATE: begin
          if (!last_s) begin
            idx_r <= idx_r + IDX_W'(1);
          end else begin
            idx_r <= idx_r;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Per-neuron state, spike and threshold storage; config writes land any time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_rf_r <= {(N_NEURONS*WIDTH){1'b0}};
      spk_rf_r   <= {N_NEURONS{1'b0}};
      thr_rf_r   <= {N_NEURONS{THR_INIT}};
    end else begin
      state_rf_r <= state_wb_s;
      spk_rf_r   <= spk_wb_s;
      if (cfg_hit_s) begin
        thr_rf_r[cfg_addr*WIDTH +: WIDTH] <= cfg_thr;
      end else begin
        thr_rf_r <= thr_rf_r;
      end
    end
  end

  // Registered status and published results; overrun is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      spike_valid <= 1'b0;
      spike_vec   <= {N_NEURONS{1'b0}};
      state_out   <= {(N_NEURONS*WIDTH){1'b0}};
      overrun     <= 1'b0;
    end else begin
      busy        <= (fsm_next_s != IDLE);
      spike_valid <= finish_s;
      overrun     <= overrun | (tick && (fsm_r != IDLE));
      if (finish_s) begin
        spike_vec <= spk_wb_s;
        state_out <= state_wb_s;
      end else begin
        spike_vec <= spike_vec;
        state_out <= state_out;
      end
    end
  end

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Self-checking bench for lif_neuron_scheduler: vector table, corner sequences, random vs model.
module tb_lif_neuron_scheduler;

  localparam int N = 4;
  localparam int W = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic [N*W-1:0] in_current = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = 2'd0;
  logic [W-1:0]  cfg_thr = 6'd0;
  logic          busy;
  logic          spike_valid;
  logic [N-1:0]  spike_vec;
  logic [N*W-1:0] state_out;
  logic          overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  int m_state[N];
  int m_thr[N];
  int m_spk[N];

  typedef struct {
    bit           rst;
    bit           we;
    logic [1:0]   waddr;
    logic [W-1:0] wthr;
    logic [N*W-1:0] in_v;
    logic [N*W-1:0] exp_st;
    logic [N-1:0] exp_sp;
  } vec_t;

  vec_t tbl[9];

  lif_neuron_scheduler #(
    .N_NEURONS       (N),
    .WIDTH           (W),
    .LEAK_SHIFT      (1),
    .RESET_THRESHOLD (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .in_current  (in_current),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_thr     (cfg_thr),
    .busy        (busy),
    .spike_valid (spike_valid),
    .spike_vec   (spike_vec),
    .state_out   (state_out),
    .overrun     (overrun)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [N*W-1:0] p4(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [W-1:0] t);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_thr = t;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Behavioural sweep: every neuron in order, straight from the LIF rules.
  task automatic model_sweep(input logic [N*W-1:0] in_v);
    int cur, sum;
    for (int i = 0; i < N; i++) begin
      cur = int'(in_v[i*W +: W]);
      if (m_thr[i] == 0) begin
        m_state[i] = 0;
        m_spk[i] = 0;
      end else begin
        sum = cur + ((m_spk[i] != 0) ? 0 : (m_state[i] >> 1));
        if (sum > 63) sum = 63;
        m_state[i] = sum;
        m_spk[i] = (sum >= m_thr[i]) ? 1 : 0;
      end
    end
  endtask

  // Tick, optionally act at cycle act_cyc (1 cfg thr2=10, 2 extra tick, 4 scramble inputs),
  // wait for spike_valid and check latency / busy duration.
  task automatic run_sweep(input string nm, input logic [N*W-1:0] in_v, input int act_cyc,
                           input int act_kind, output logic [N*W-1:0] st, output logic [N-1:0] sp);
    int cyc;
    int bc;
    @(negedge clk);
    in_current = in_v;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc = 1;
    bc = 0;
    while (cyc < 40) begin
      if (busy) bc++;
      if (spike_valid) break;
      if (cyc == act_cyc) begin
        case (act_kind)
          1: begin cfg_we = 1'b1; cfg_addr = 2'd2; cfg_thr = 6'd10; end
          2: tick = 1'b1;
          4: in_current = 24'($urandom);
          default: ;
        endcase
      end
      @(negedge clk);
      cfg_we = 1'b0;
      tick = 1'b0;
      cyc++;
    end
    check({nm, "_latency"}, 32'(cyc), 32'd9);
    check({nm, "_busy_cycles"}, 32'(bc), 32'd9);
    st = state_out;
    sp = spike_vec;
    @(negedge clk);
    check({nm, "_idle_after"}, {30'd0, busy, spike_valid}, 32'd0);
  endtask

  logic [N*W-1:0] st;
  logic [N-1:0]   sp;
  int             cnt;
  logic [N*W-1:0] rin;

  // Test sequence.
  initial begin
    tbl[0] = '{1'b1, 1'b0, 2'd0, 6'd0,  p4(0, 0, 0, 0),   p4(0, 0, 0, 0),   4'b0000};
    tbl[1] = '{1'b1, 1'b0, 2'd0, 6'd0,  p4(20, 0, 0, 0),  p4(20, 0, 0, 0),  4'b0000};
    tbl[2] = '{1'b0, 1'b0, 2'd0, 6'd0,  p4(20, 0, 0, 0),  p4(30, 0, 0, 0),  4'b0000};
    tbl[3] = '{1'b0, 1'b0, 2'd0, 6'd0,  p4(20, 0, 0, 0),  p4(35, 0, 0, 0),  4'b0001};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 6'd0,  p4(20, 0, 0, 0),  p4(20, 0, 0, 0),  4'b0000};
    tbl[5] = '{1'b1, 1'b1, 2'd1, 6'd63, p4(0, 63, 0, 0),  p4(0, 63, 0, 0),  4'b0010};
    tbl[6] = '{1'b0, 1'b0, 2'd0, 6'd0,  p4(0, 63, 0, 0),  p4(0, 63, 0, 0),  4'b0010};
    tbl[7] = '{1'b1, 1'b1, 2'd2, 6'd0,  p4(0, 0, 63, 40), p4(0, 0, 0, 40),  4'b1000};
    tbl[8] = '{1'b0, 1'b0, 2'd0, 6'd0,  p4(0, 0, 63, 40), p4(0, 0, 0, 40),  4'b1000};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(spike_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_spike_vec", 32'(spike_vec), 32'd0);
    check("rst_state_out", 32'(state_out), 32'd0);

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) pulse_reset();
      if (tbl[i].we) cfg_write(tbl[i].waddr, tbl[i].wthr);
      run_sweep($sformatf("vec%0d", i), tbl[i].in_v, 0, 0, st, sp);
      check($sformatf("vec%0d_state", i), 32'(st), 32'(tbl[i].exp_st));
      check($sformatf("vec%0d_spike", i), 32'(sp), 32'(tbl[i].exp_sp));
    end

    // Threshold write after neuron2 is latched only affects the following sweep.
    run_sweep("thr_mid", p4(0, 0, 63, 0), 6, 1, st, sp);
    check("thr_mid_state2", 32'(st[17:12]), 32'd0);
    check("thr_mid_spike2", 32'(sp[2]), 32'd0);
    run_sweep("thr_next", p4(0, 0, 63, 0), 0, 0, st, sp);
    check("thr_next_state2", 32'(st[17:12]), 32'd63);
    check("thr_next_spike2", 32'(sp[2]), 32'd1);

    // Tick while busy: ignored, overrun sticks.
    check("ovr_before", 32'(overrun), 32'd0);
    run_sweep("ovr", p4(0, 0, 0, 0), 3, 2, st, sp);
    check("ovr_set", 32'(overrun), 32'd1);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (spike_valid) cnt++;
    end
    check("ovr_no_extra_sweep", 32'(cnt), 32'd0);
    run_sweep("ovr_again", p4(0, 0, 0, 0), 0, 0, st, sp);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-sweep (with a coincident cfg write that must lose).
    @(negedge clk);
    in_current = p4(20, 0, 20, 0);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_thr = 6'd5;
    @(negedge clk);
    reset = 1'b0; cfg_we = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(spike_valid), 32'd0);
    check("mrst_spike_vec", 32'(spike_vec), 32'd0);
    check("mrst_state_out", 32'(state_out), 32'd0);
    check("mrst_overrun", 32'(overrun), 32'd0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (spike_valid) cnt++;
    end
    check("mrst_no_valid", 32'(cnt), 32'd0);
    run_sweep("mrst_after", p4(20, 0, 20, 0), 0, 0, st, sp);
    check("mrst_after_state", 32'(st), 32'(p4(20, 0, 20, 0)));
    check("mrst_after_spike", 32'(sp), 32'd0);

    // Randomized sweeps against the behavioural model.
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0; m_thr[i] = 32; m_spk[i] = 0;
    end
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        logic [1:0] a;
        logic [W-1:0] t;
        a = 2'($urandom_range(0, 3));
        t = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        cfg_write(a, t);
        m_thr[a] = int'(t);
      end
      rin = 24'($urandom);
      run_sweep($sformatf("rnd%0d", it), rin, int'($urandom_range(1, 8)),
                ($urandom_range(0, 1) == 1) ? 4 : 0, st, sp);
      model_sweep(rin);
      check($sformatf("rnd%0d_state", it), 32'(st),
            32'(p4(m_state[0], m_state[1], m_state[2], m_state[3])));
      check($sformatf("rnd%0d_spike", it), 32'(sp),
            {28'd0, m_spk[3][0], m_spk[2][0], m_spk[1][0], m_spk[0][0]});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
